eeprom_seq: RTL
===============

Name: eeprom_seq

Overview:
Host-side sequencer placed directly upstream of the serial EEPROM read/write controller. Owns a 16-byte buffer and runs a burst job (write, read or verify) over consecutive EEPROM addresses. Each byte is one single-byte controller transaction, issued through the controller's WR/RD/ADDR/DATA/ACK handshake. Write jobs insert a programmable gap between bytes to cover the EEPROM internal write time.

Parameters:
DEPTH, 16, buffer entries; also the maximum burst length.
GAP_CYCLES, 1000, idle cycles after each write ACK before the next issue.
TIMEOUT, 4095, maximum WAIT_ACK cycles before the job aborts.

Ports:
CLK  in  1  system clock; all logic on posedge.
RESET  in  1  asynchronous, active-low reset.
start  in  1  job request; accepted only in IDLE.
mode  in  2  00 write, 01 read, 10 verify, 11 reserved (accepted as read).
base_addr  in  11  EEPROM address of buffer entry 0.
len  in  5  bytes to transfer, 0..16; values above 16 clamp to 16.
buf_we  in  1  host buffer write; ignored while busy.
buf_idx  in  4  host buffer index for write and read.
buf_wdata  in  8  host write data.
buf_rdata  out  8  buf[buf_idx], combinational.
busy  out  1  job in progress.
done  out  1  one-cycle pulse at job end, success or error.
err  out  1  timeout flag; sticky until the next accepted start.
mismatch_cnt  out  5  verify mismatches in the last job.
first_bad_idx  out  4  index of the first verify mismatch.
WR  out  1  write request to the controller, one-cycle pulse.
RD  out  1  read request to the controller, one-cycle pulse.
ADDR  out  11  EEPROM address to the controller.
DATA  inout  8  parallel data shared with the controller.
ACK  in  1  controller end-of-transaction pulse.

Behaviour:
- Reset (RESET=0, asynchronous):
  - State IDLE.
  - WR=RD=0, ADDR=0, DATA released (z), busy=0, done=0, err=0, mismatch_cnt=0, first_bad_idx=0, all counters 0.
  - Buffer contents are not cleared.
  - Reset mid-job abandons the job silently; the controller is reset by its own reset.
- States: IDLE, ISSUE, WAIT_ACK, GAP, DONE.
- IDLE:
  - start=1 latches mode, base_addr and min(len,16); sets idx=0.
  - Clears err, mismatch_cnt and first_bad_idx; sets busy=1.
  - len=0 goes to DONE; otherwise goes to ISSUE.
- ISSUE (one cycle):
  - ADDR=(base+idx) mod 2048, so addresses wrap 0x7FF to 0x000.
  - Write mode: WR=1 and DATA driven with buf[idx]. Read/verify: RD=1 and DATA at z.
- WAIT_ACK:
  - WR=RD=0. ADDR held.
  - Write mode keeps driving DATA until ACK is sampled; read/verify keep DATA at z.
  - Timer counts cycles.
- On ACK=1 in WAIT_ACK, same edge:
  - Read: buf[idx] <= DATA.
  - Verify: compare DATA with buf[idx]. On mismatch, increment mismatch_cnt (max 16, no overflow). On the first mismatch, set first_bad_idx=idx. The buffer is unchanged.
  - Then idx++. If idx==len, go to DONE. Otherwise go to GAP, loaded with GAP_CYCLES for write and 1 for read/verify.
- Timeout: timer reaches TIMEOUT with no ACK. Set err=1, release DATA, go to DONE. Remaining bytes are skipped.
- GAP: count down to 0, then go to ISSUE. ACK seen here is ignored.
- DONE (one cycle): done=1 and busy=0 in that cycle, then IDLE.
- Latency per byte = 2 + controller latency + gap. A job of len N issues exactly N WR or RD pulses.
- Ignored inputs:
  - start while busy is ignored.
  - buf_we while busy is ignored; the host can never corrupt an active job.
  - buf_we and a read-store to the same index cannot collide.
- Bus rule: the DATA output enable is never asserted in read/verify mode or outside ISSUE/WAIT_ACK.

Decomposition:
- Shared package eeprom_pkg: mode encodings (MODE_WR, MODE_RD, MODE_VFY), sequencer state encoding, EEPROM address width (11), data width (8).
- Sub-module seq_buf: 16x8 register file. Host write port and sequencer write port are muxed by busy. It has two asynchronous read ports: host buf_idx and sequencer idx.

Test Plan:
- Write job: load buf with 0xA0..0xAF, base=0x120, len=16, GAP_CYCLES=8, model ACK 40 cycles after WR. Expect 16 WR pulses on ADDR 0x120..0x12F, DATA matching at each ACK, ≥8 idle cycles between ACK and the next WR, one done pulse, err=0.
- Read job: model returns ~ADDR[7:0], base=0x7FE, len=4. Expect ADDR 0x7FE, 0x7FF, 0x000, 0x001. buf[0..3] = 0x01, 0x00, 0xFF, 0xFE. DATA never driven.
- Verify job: buf=0x00..0x0F, model returns idx except byte 5=0x55 and byte 9=0x99. Expect mismatch_cnt=2, first_bad_idx=5, buf unchanged.
- Timeout: model never ACKs, TIMEOUT=100. Expect done ~101 cycles after RD, err=1, busy=0, only one RD issued. The next start clears err.
- Boundaries: len=0, then one cycle later done=1 with no WR/RD. len=20 gives exactly 16 transactions. start and buf_we during a job have no effect.
- Reset mid-WAIT_ACK of a write job: DATA goes z and busy=0 immediately (asynchronously). After release, a new job runs normally.

Source files
------------

// File: rtl/eeprom_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eeprom_pkg
//  Description : Shared types and constants for the EEPROM burst sequencer:
//                job mode encodings, sequencer state encoding, EEPROM
//                address/data widths and the burst-length clamp helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package eeprom_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;

    // Reserved encoding 2'b11 is accepted and behaves as a read job.
    typedef enum logic [1:0] {
        MODE_WR  = 2'b00,
        MODE_RD  = 2'b01,
        MODE_VFY = 2'b10,
        MODE_RSV = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_GAP      = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // Saturate a requested burst length to the buffer depth.
    function automatic logic [4:0] clamp_len(input logic [4:0] req_len,
                                             input logic [4:0] max_len);
        return (req_len > max_len) ? max_len : req_len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_buf.sv
`default_nettype none
// ============================================================================
//  Module      : seq_buf
//  Description : DEPTH x 8 register file for the sequencer. One write port
//                shared between host and sequencer (selected by busy) and two
//                asynchronous read ports. Contents are never reset.
//  Ports       : clk                 - clock
//                busy                - 1 selects the sequencer write port
//                host_we/idx/wdata   - host write port
//                host_rdata          - host asynchronous read data
//                seq_we/idx/wdata    - sequencer write port
//                seq_rdata           - sequencer asynchronous read data
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_buf
    import eeprom_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic              clk,
    input  logic              busy,
    input  logic              host_we,
    input  logic [IDX_W-1:0]  host_idx,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              seq_we,
    input  logic [IDX_W-1:0]  seq_idx,
    input  logic [DATA_W-1:0] seq_wdata,
    output logic [DATA_W-1:0] seq_rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // While a job runs the host port is shut off, so a host write can never
    // collide with a read-store from the controller.
    always_ff @(posedge clk) begin
        if (busy) begin
            if (seq_we) begin
                mem[seq_idx] <= seq_wdata;
            end
        end else if (host_we) begin
            mem[host_idx] <= host_wdata;
        end
    end

    assign host_rdata = mem[host_idx];
    assign seq_rdata  = mem[seq_idx];

endmodule
`default_nettype wire

// File: rtl/eeprom_seq.sv
`default_nettype none
// ============================================================================
//  Module      : eeprom_seq
//  Description : Host-side burst sequencer in front of a serial EEPROM
//                controller. Runs write / read / verify jobs of up to DEPTH
//                single-byte transactions over consecutive addresses, using
//                the controller WR/RD/ADDR/DATA/ACK handshake.
//  Ports       : CLK, RESET (async, active low)
//                start, mode, base_addr, len      - job request
//                buf_we, buf_idx, buf_wdata       - host buffer write
//                buf_rdata                        - host buffer read
//                busy, done, err                  - job status
//                mismatch_cnt, first_bad_idx      - verify results
//                WR, RD, ADDR, DATA, ACK          - controller interface
//  Revision    : 1.0 - initial release
// ============================================================================
module eeprom_seq
    import eeprom_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 1000,
    parameter int TIMEOUT    = 4095
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [4:0]        len,
    input  logic              buf_we,
    input  logic [3:0]        buf_idx,
    input  logic [DATA_W-1:0] buf_wdata,
    output logic [DATA_W-1:0] buf_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [4:0]        mismatch_cnt,
    output logic [3:0]        first_bad_idx,
    output logic              WR,
    output logic              RD,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] DATA,
    input  logic              ACK
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

    state_t            state_q, state_d;
    mode_t             mode_q, mode_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [4:0]        len_q, len_d;
    logic [4:0]        idx_q, idx_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              err_q, err_d;
    logic [4:0]        mcnt_q, mcnt_d;
    logic [3:0]        fbad_q, fbad_d;

    logic              seq_we;
    logic [DATA_W-1:0] seq_rdata;
    logic [4:0]        len_c;
    logic              is_wr;
    logic              data_oe;

    assign len_c = clamp_len(len, 5'(DEPTH));
    assign is_wr = (mode_q == MODE_WR);

    seq_buf #(
        .DEPTH (DEPTH),
        .IDX_W (4)
    ) u_buf (
        .clk        (CLK),
        .busy       (busy),
        .host_we    (buf_we),
        .host_idx   (buf_idx),
        .host_wdata (buf_wdata),
        .host_rdata (buf_rdata),
        .seq_we     (seq_we),
        .seq_idx    (idx_q[3:0]),
        .seq_wdata  (DATA),
        .seq_rdata  (seq_rdata)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_WR;
            base_q  <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            tmr_q   <= '0;
            gap_q   <= '0;
            err_q   <= 1'b0;
            mcnt_q  <= '0;
            fbad_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
            mcnt_q  <= mcnt_d;
            fbad_q  <= fbad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        base_d  = base_q;
        addr_d  = addr_q;
        len_d   = len_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        gap_d   = gap_q;
        err_d   = err_q;
        mcnt_d  = mcnt_q;
        fbad_d  = fbad_q;
        seq_we  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode_t'(mode);
                    base_d  = base_addr;
                    addr_d  = base_addr;
                    len_d   = len_c;
                    idx_d   = '0;
                    tmr_d   = '0;
                    err_d   = 1'b0;
                    mcnt_d  = '0;
                    fbad_d  = '0;
                    state_d = (len_c == 5'd0) ? S_DONE : S_ISSUE;
                end
            end

            S_ISSUE: begin
                tmr_d   = '0;
                state_d = S_WAIT_ACK;
            end

            S_WAIT_ACK: begin
                if (ACK) begin
                    if (mode_q == MODE_VFY) begin
                        if (DATA != seq_rdata) begin
                            if (mcnt_q == 5'd0) begin
                                fbad_d = idx_q[3:0];
                            end
                            if (mcnt_q < 5'(DEPTH)) begin
                                mcnt_d = mcnt_q + 5'd1;
                            end
                        end
                    end else if (!is_wr) begin
                        seq_we = 1'b1;
                    end
                    idx_d = idx_q + 5'd1;
                    if (idx_d == len_q) begin
                        state_d = S_DONE;
                    end else begin
                        // Address for the next ISSUE is prepared here so it is
                        // stable for the whole request; 11-bit add wraps 7FF->000.
                        addr_d  = base_q + ADDR_W'(idx_d);
                        gap_d   = is_wr ? GAP_W'(GAP_CYCLES) : GAP_W'(1);
                        state_d = S_GAP;
                    end
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    // WAIT_ACK has lasted TIMEOUT cycles: abandon the job.
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            S_GAP: begin
                if (gap_q <= GAP_W'(1)) begin
                    state_d = S_ISSUE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus drive is decoded straight from state so an asynchronous reset
    // releases DATA immediately.
    assign data_oe = is_wr && ((state_q == S_ISSUE) || (state_q == S_WAIT_ACK));
    assign DATA    = data_oe ? seq_rdata : {DATA_W{1'bz}};

    assign WR            = (state_q == S_ISSUE) && is_wr;
    assign RD            = (state_q == S_ISSUE) && !is_wr;
    assign ADDR          = addr_q;
    assign busy          = (state_q == S_ISSUE) || (state_q == S_WAIT_ACK) || (state_q == S_GAP);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;
    assign mismatch_cnt  = mcnt_q;
    assign first_bad_idx = fbad_q;

endmodule
`default_nettype wire
